// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B, LSB first, one bit per clock, start/busy/done handshake.
// Optional macro SUB_OVERFLOW_EN adds output V (signed overflow of A - B).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
`ifdef SUB_OVERFLOW_EN
  output logic             V,
`endif
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;
  logic             a_msb_q, b_msb_q;

  // Handshake: a request is accepted only when start=1 in IDLE or DONE;
  // busy marks RUN, done is a one-cycle pulse in DONE; they never overlap.
  logic accept, last_bit;
  logic a_bit, b_bit, d_bit, borrow_d;

  always_comb begin
    accept   = 1'b0;
    last_bit = 1'b0;
    state_d  = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST_CNT) begin
          last_bit = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Full subtractor on the current LSBs plus the stored borrow.
  always_comb begin
    a_bit    = a_sr[0];
    b_bit    = b_sr[0];
    d_bit    = a_bit ^ b_bit ^ borrow_q;
    borrow_d = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
    end else if (accept) begin
      a_sr     <= A;
      b_sr     <= B;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= A[WIDTH-1];
      b_msb_q  <= B[WIDTH-1];
    end else if (state_q == RUN) begin
      a_sr     <= a_sr >> 1;
      b_sr     <= b_sr >> 1;
      res_sr   <= {d_bit, res_sr[WIDTH-1:1]};
      borrow_q <= borrow_d;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  // Visible result only moves on the final RUN edge, so it holds across a new run.
  always_ff @(posedge clk) begin
    if (rst) begin
      Diff <= '0;
      Bout <= 1'b0;
    end else if (last_bit) begin
      Diff <= {d_bit, res_sr[WIDTH-1:1]};
      Bout <= borrow_d;
    end
  end

`ifdef SUB_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (rst)           V <= 1'b0;
    else if (last_bit) V <= (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
  end
`endif

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, bout;
  logic [W-1:0] diff;
  logic [1:0]   state_dbg;
`ifdef SUB_OVERFLOW_EN
  logic         v;
`endif

  int errors = 0;
  int checks = 0;
  logic [W:0] exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
    .busy(busy), .done(done), .Diff(diff), .Bout(bout),
`ifdef SUB_OVERFLOW_EN
    .V(v),
`endif
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bout;
    logic         v;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done; returns number of edges waited, checks busy on the way
  // and that the visible result holds its previous value during RUN.
  task automatic wait_done(input logic [W:0] prev, output int n);
    bit hold_ok = 1'b1;
    bit busy_ok = 1'b1;
    n = 0;
    while (!done && n < 20) begin
      if (!busy) busy_ok = 1'b0;
      if ({bout, diff} !== prev) hold_ok = 1'b0;
      tick();
      n++;
    end
    check("busy_during_run", {31'd0, busy_ok}, 32'd1);
    check("result_hold", {31'd0, hold_ok}, 32'd1);
    check("done_no_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_op(input vec_t t, input string tag);
    logic [W:0] prev;
    int n;
    prev  = {bout, diff};
    a     = t.a;
    b     = t.b;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = $urandom_range(0, 255);
    b     = $urandom_range(0, 255);
    exp_q.push_back({t.bout, t.diff});
    wait_done(prev, n);
    check({tag, "_latency"}, n, W);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    if (exp_q.size() > 0) check({tag, "_result"}, {bout, diff}, exp_q.pop_front());
`ifdef SUB_OVERFLOW_EN
    check({tag, "_v"}, {31'd0, v}, {31'd0, t.v});
`endif
    tick();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {30'd0, state_dbg}, 32'd0);
  endtask

  initial begin
    int n;
    vec_t t;
    logic [W:0] prev;
    vecs[0] = '{8'd10, 8'd3,  8'h07, 1'b0, 1'b0};
    vecs[1] = '{8'd3,  8'd10, 8'hF9, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h55, 8'h55, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_diff", {24'd0, diff}, 32'd0);
    check("reset_bout", {31'd0, bout}, 32'd0);
    check("reset_state", {30'd0, state_dbg}, 32'd0);

    for (int i = 0; i < 7; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: start held high; new operands presented only on done cycles.
    a = 8'h10; b = 8'h01; start = 1'b1;
    exp_q.push_back({1'b0, 8'h0F});
    tick();
    for (int k = 0; k < 3; k++) begin
      prev = {bout, diff};
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      wait_done(prev, n);
      check("b2b_latency", n, W);
      if (exp_q.size() > 0) check("b2b_result", {bout, diff}, exp_q.pop_front());
      if (k == 0) begin a = 8'h01; b = 8'h03; exp_q.push_back({1'b1, 8'hFE}); end
      if (k == 1) begin a = 8'hC8; b = 8'h64; exp_q.push_back({1'b0, 8'h64}); end
      if (k == 2) start = 1'b0;
      tick();
      check("b2b_next_busy", {31'd0, busy}, (k < 2) ? 32'd1 : 32'd0);
    end

    // Reset mid-run discards the partial result.
    a = 8'hF0; b = 8'h0F; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_diff", {24'd0, diff}, 32'd0);
    check("midrst_bout", {31'd0, bout}, 32'd0);
    check("midrst_state", {30'd0, state_dbg}, 32'd0);
    t = '{8'h20, 8'h01, 8'h1F, 1'b0, 1'b0};
    run_op(t, "after_rst");

    // Hold: old result 0x1F/0 stays visible until the new one completes.
    t = '{8'h01, 8'h02, 8'hFF, 1'b1, 1'b0};
    run_op(t, "hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
